// File: rtl/imm_gen_pkg.sv
// ============================================================================
// Module      : imm_gen_pkg
// Description : Shared types, opcode constants and sign-extension helper for
//               the immediate-decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_B     = 3'd3,
        IMM_U     = 3'd4,
        IMM_J     = 3'd5,
        IMM_CI    = 3'd6,
        IMM_CB_CJ = 3'd7
    } imm_type_e;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Sign-extends the low nbits of v to 64 bits; callers truncate to XLEN.
    function automatic logic [63:0] sext(input logic [31:0] v, input int unsigned nbits);
        logic signed [63:0] t;
        t = $signed({v << (32 - nbits), 32'h0});
        return t >>> (64 - nbits);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_skid_buf.sv
// ============================================================================
// Module      : imm_skid_buf
// Description : Generic 2-entry valid/ready skid buffer (output register plus
//               one skid slot) with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_skid_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    generate
        if (DEPTH != 2) begin : g_depth_check
            $error("imm_skid_buf: only DEPTH=2 is supported");
        end
    endgenerate

    logic         r_out_valid;
    logic [W-1:0] r_out_data;
    logic         r_skid_full;
    logic [W-1:0] r_skid_data;
    logic         r_in_ready;

    logic w_in_fire;
    logic w_out_free;
    logic w_skid_full_nxt;

    assign w_in_fire       = i_valid & r_in_ready;
    assign w_out_free      = ~r_out_valid | i_ready;
    assign w_skid_full_nxt = w_out_free ? 1'b0 : (r_skid_full | w_in_fire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_skid_full <= 1'b0;
            r_skid_data <= '0;
            r_in_ready  <= 1'b0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            // in_ready is low whenever the skid is full, so the two sources never collide.
            if (w_out_free) begin
                if (r_skid_full) begin
                    r_out_data  <= r_skid_data;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= w_in_fire;
                    if (w_in_fire) begin
                        r_out_data <= i_data;
                    end
                end
            end else if (w_in_fire) begin
                r_skid_data <= i_data;
            end
            r_skid_full <= w_skid_full_nxt;
            r_in_ready  <= ~w_skid_full_nxt;
        end
    end

    assign o_ready = r_in_ready;
    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;

endmodule

`default_nettype wire

// File: rtl/imm_decode_stage.sv
// ============================================================================
// Module      : imm_decode_stage
// Description : Registered immediate-decode stage: format classification,
//               sign-extended immediate and PC+imm target behind a 2-entry skid.
//               Optional RVC decode enabled by defining RVC_IMM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_decode_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SKID_DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ir,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output imm_type_e       out_type,
    output logic            out_illegal,
    output logic            out_rvc
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        imm_type_e       typ;
        logic            illegal;
        logic            rvc;
    } payload_t;

    imm_type_e       w_type;
    logic [XLEN-1:0] w_imm;
    logic            w_illegal;
    logic            w_rvc;
    payload_t        w_in_pl;
    payload_t        w_out_pl;

    always_comb begin
        w_type    = IMM_NONE;
        w_imm     = '0;
        w_illegal = 1'b1;
        w_rvc     = 1'b0;
`ifdef RVC_IMM_EN
        if (in_ir[1:0] != 2'b11) begin
            w_rvc = 1'b1;
            case ({in_ir[1:0], in_ir[15:13]})
                5'b01_000, 5'b01_010: begin
                    w_type    = IMM_CI;
                    w_imm     = XLEN'(sext({26'b0, in_ir[12], in_ir[6:2]}, 6));
                    w_illegal = 1'b0;
                end
                5'b01_001, 5'b01_101: begin
                    w_type    = IMM_CB_CJ;
                    w_imm     = XLEN'(sext({20'b0, in_ir[12], in_ir[8], in_ir[10:9], in_ir[6],
                                            in_ir[7], in_ir[2], in_ir[11], in_ir[5:3], 1'b0}, 12));
                    w_illegal = 1'b0;
                end
                5'b01_110, 5'b01_111: begin
                    w_type    = IMM_CB_CJ;
                    w_imm     = XLEN'(sext({23'b0, in_ir[12], in_ir[6:5], in_ir[2],
                                            in_ir[11:10], in_ir[4:3], 1'b0}, 9));
                    w_illegal = 1'b0;
                end
                // C.LW / C.SW: unsigned word-scaled offsets
                5'b00_010, 5'b00_110: begin
                    w_type    = in_ir[15] ? IMM_S : IMM_I;
                    w_imm     = XLEN'({in_ir[5], in_ir[12:10], in_ir[6], 2'b00});
                    w_illegal = 1'b0;
                end
                default: ;
            endcase
        end else begin
`else
        begin
`endif
            w_illegal = 1'b0;
            case (in_ir[6:0])
                OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                    w_type = IMM_I;
                    w_imm  = XLEN'(sext({20'b0, in_ir[31:20]}, 12));
                end
                OPC_STORE: begin
                    w_type = IMM_S;
                    w_imm  = XLEN'(sext({20'b0, in_ir[31:25], in_ir[11:7]}, 12));
                end
                OPC_BRANCH: begin
                    w_type = IMM_B;
                    w_imm  = XLEN'(sext({19'b0, in_ir[31], in_ir[7], in_ir[30:25],
                                         in_ir[11:8], 1'b0}, 13));
                end
                OPC_LUI, OPC_AUIPC: begin
                    w_type = IMM_U;
                    w_imm  = XLEN'(sext({in_ir[31:12], 12'b0}, 32));
                end
                OPC_JAL: begin
                    w_type = IMM_J;
                    w_imm  = XLEN'(sext({11'b0, in_ir[31], in_ir[19:12], in_ir[20],
                                         in_ir[30:21], 1'b0}, 21));
                end
                default: begin
                    w_illegal = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        w_in_pl.imm     = w_imm;
        w_in_pl.target  = in_pc + w_imm;
        w_in_pl.typ     = w_type;
        w_in_pl.illegal = w_illegal;
        w_in_pl.rvc     = w_rvc;
    end

    imm_skid_buf #(
        .W     ($bits(payload_t)),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk     (CLK),
        .rst_n   (RST_N),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_pl),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_out_pl)
    );

    assign out_imm     = w_out_pl.imm;
    assign out_target  = w_out_pl.target;
    assign out_type    = w_out_pl.typ;
    assign out_illegal = w_out_pl.illegal;
    assign out_rvc     = w_out_pl.rvc;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_stage.sv
// ============================================================================
// Module      : tb_imm_decode_stage
// Description : Directed, table-driven bench for imm_decode_stage (XLEN=32),
//               plus back-pressure, flush and reset-mid-stall sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_decode_stage;
    import imm_gen_pkg::*;

    logic        CLK;
    logic        RST_N;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    imm_type_e   out_type;
    logic        out_illegal;
    logic        out_rvc;

    int n_checks = 0;
    int n_fail   = 0;

    imm_decode_stage #(.XLEN(32), .SKID_DEPTH(2)) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ir       (in_ir),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_target  (out_target),
        .out_type    (out_type),
        .out_illegal (out_illegal),
        .out_rvc     (out_rvc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        imm_type_e   t;
        logic [31:0] imm;
        logic [31:0] tgt;
        logic        ill;
        logic        rvc;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input imm_type_e t, input logic [31:0] imm,
                           input logic [31:0] tgt);
        chk({name, " valid"},  out_valid, 1'b1);
        chk({name, " type"},   out_type, t);
        chk({name, " imm"},    out_imm, imm);
        chk({name, " target"}, out_target, tgt);
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc);
        in_valid = v;
        in_ir    = ir;
        in_pc    = pc;
    endtask

    // Two accepts with downstream stalled: output register + skid both hold data.
    task automatic fill_skid();
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h500);
        @(negedge CLK);
        drive(1'b1, 32'h12345037, 32'h504);
        @(negedge CLK);
        chk("fill in_ready", in_ready, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{32'h001000EF, 32'h1000,     IMM_J,    32'h800,      32'h1800,     1'b0, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 32'h100,      IMM_B,    32'hFFFFFFFC, 32'hFC,       1'b0, 1'b0};
        vecs[2]  = '{32'hFFF00093, 32'h200,      IMM_I,    32'hFFFFFFFF, 32'h1FF,      1'b0, 1'b0};
        vecs[3]  = '{32'h12345037, 32'h10,       IMM_U,    32'h12345000, 32'h12345010, 1'b0, 1'b0};
        vecs[4]  = '{32'h0000007F, 32'h300,      IMM_NONE, 32'h0,        32'h300,      1'b1, 1'b0};
        vecs[5]  = '{32'hFE512C23, 32'h400,      IMM_S,    32'hFFFFFFF8, 32'h3F8,      1'b0, 1'b0};
        vecs[6]  = '{32'h00001017, 32'h2000,     IMM_U,    32'h1000,     32'h3000,     1'b0, 1'b0};
        vecs[7]  = '{32'h00008067, 32'h50,       IMM_I,    32'h0,        32'h50,       1'b0, 1'b0};
        vecs[8]  = '{32'h80000083, 32'h1000,     IMM_I,    32'hFFFFF800, 32'h800,      1'b0, 1'b0};
        vecs[9]  = '{32'hFFDFF0EF, 32'h10,       IMM_J,    32'hFFFFFFFC, 32'hC,        1'b0, 1'b0};
        vecs[10] = '{32'h00001037, 32'hFFFFFFF0, IMM_U,    32'h1000,     32'hFF0,      1'b0, 1'b0};
        vecs[11] = '{32'h00000073, 32'h60,       IMM_I,    32'h0,        32'h60,       1'b0, 1'b0};
        vecs[12] = '{32'h7FF00013, 32'h70,       IMM_I,    32'h7FF,      32'h86F,      1'b0, 1'b0};
`ifdef RVC_IMM_EN
        vecs[13] = '{32'h000050FD, 32'h40,       IMM_CI,   32'hFFFFFFFF, 32'h3F,       1'b0, 1'b1};
`else
        vecs[13] = '{32'h000050FD, 32'h40,       IMM_NONE, 32'h0,        32'h40,       1'b1, 1'b0};
`endif

        RST_N     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        #12;
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset in_ready", in_ready, 1'b0);
        chk("reset out_imm", out_imm, 32'h0);
        chk("reset out_target", out_target, 32'h0);
        chk("reset out_type", out_type, IMM_NONE);

        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("in_ready before first edge", in_ready, 1'b0);
        @(negedge CLK);
        chk("in_ready after first edge", in_ready, 1'b1);
        chk("idle out_valid", out_valid, 1'b0);

        // Streaming at one per cycle; each result is checked one cycle after it is presented.
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, vecs[i].ir, vecs[i].pc);
            @(negedge CLK);
            chk_out($sformatf("vec%0d", i), vecs[i].t, vecs[i].imm, vecs[i].tgt);
            chk($sformatf("vec%0d illegal", i), out_illegal, vecs[i].ill);
            chk($sformatf("vec%0d rvc", i), out_rvc, vecs[i].rvc);
            chk($sformatf("vec%0d in_ready", i), in_ready, 1'b1);
        end
        drive(1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("drain out_valid", out_valid, 1'b0);

        // Back-pressure: ADDI, LUI, JAL with out_ready low for three cycles.
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h200);
        @(negedge CLK);
        chk_out("bp1 addi", IMM_I, 32'hFFFFFFFF, 32'h1FF);
        chk("bp1 in_ready", in_ready, 1'b1);
        drive(1'b1, 32'h12345037, 32'h10);
        @(negedge CLK);
        chk("bp2 in_ready", in_ready, 1'b0);
        chk_out("bp2 hold addi", IMM_I, 32'hFFFFFFFF, 32'h1FF);
        drive(1'b1, 32'h001000EF, 32'h1000);
        @(negedge CLK);
        chk("bp3 in_ready", in_ready, 1'b0);
        chk_out("bp3 hold addi", IMM_I, 32'hFFFFFFFF, 32'h1FF);
        out_ready = 1'b1;
        @(negedge CLK);
        chk_out("bp4 lui", IMM_U, 32'h12345000, 32'h12345010);
        chk("bp4 in_ready", in_ready, 1'b1);
        @(negedge CLK);
        chk_out("bp5 jal", IMM_J, 32'h800, 32'h1800);
        drive(1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("bp6 out_valid", out_valid, 1'b0);

        // Flush with the skid full; the input presented alongside flush is dropped.
        fill_skid();
        flush = 1'b1;
        drive(1'b1, 32'h001000EF, 32'h1000);
        @(negedge CLK);
        chk("flush out_valid", out_valid, 1'b0);
        chk("flush in_ready", in_ready, 1'b1);
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("post-flush out_valid a", out_valid, 1'b0);
        @(negedge CLK);
        chk("post-flush out_valid b", out_valid, 1'b0);
        drive(1'b1, 32'hFE000EE3, 32'h100);
        @(negedge CLK);
        chk_out("post-flush beq", IMM_B, 32'hFFFFFFFC, 32'hFC);
        drive(1'b0, 32'h0, 32'h0);
        @(negedge CLK);

        // Asynchronous reset with the skid full.
        fill_skid();
        drive(1'b0, 32'h0, 32'h0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async rst out_valid", out_valid, 1'b0);
        chk("async rst in_ready", in_ready, 1'b0);
        chk("async rst out_imm", out_imm, 32'h0);
        @(negedge CLK);
        RST_N     = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        chk("post-rst out_valid a", out_valid, 1'b0);
        chk("post-rst in_ready", in_ready, 1'b1);
        @(negedge CLK);
        chk("post-rst out_valid b", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
